signed_div_seq: RTL and testbench
=================================

# signed_div_seq

Multi-cycle signed 32-bit divide sequencer for the MiniSRC ALU, backing the DIV instruction that writes HI (remainder) and LO (quotient). It owns a single shared two's-complement negation unit and sequences it in four places: magnitude of the dividend, magnitude of the divisor, sign fix-up of the quotient, and sign fix-up of the remainder. Between those steps it runs an unsigned restoring division. Results follow C truncation semantics: the quotient rounds toward zero and the remainder takes the dividend's sign.

## Interface
- WIDTH, 32, operand and result width.
- clock  in  1  rising-edge system clock.
- reset  in  1  synchronous, active-high; returns block to IDLE.
- start  in  1  request a divide; sampled only in IDLE.
- dividend  in  WIDTH  signed dividend, sampled with start.
- divisor  in  WIDTH  signed divisor, sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; results valid this cycle.
- quotient  out  WIDTH  signed quotient (LO).
- remainder  out  WIDTH  signed remainder (HI).
- div_by_zero  out  1  set with done when divisor == 0; held until next accepted start.

## Operation
- States: IDLE → ABS_A → ABS_B → DIV → FIX_Q → FIX_R → DONE → IDLE.
- IDLE
  - start=1 latches the operands and captures q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
  - Clears div_by_zero.
  - Next state is ABS_A.
- ABS_A: the negator is enabled iff the dividend is negative. Its output is latched as the unsigned magnitude A.
- ABS_B: same as ABS_A, producing magnitude B.
  - If B == 0, go to DONE with quotient=0, remainder=dividend (original, unmodified) and div_by_zero=1.
  - Otherwise, go to DIV.
- DIV: WIDTH iterations of restoring division, driven by a counter.
  - R (WIDTH+1 bits) = {R[WIDTH-1:0], A[msb]}; A shifts left.
  - If R − B ≥ 0, then R = R − B and the shifted-in quotient bit is 1; otherwise the bit is 0.
  - Magnitudes are treated as unsigned WIDTH-bit values, so 2^(WIDTH−1) is a legal magnitude.
- FIX_Q: quotient = negate(Q) if q_neg, else Q.
- FIX_R: remainder = negate(R[WIDTH-1:0]) if r_neg, else R.
- DONE: done=1 for exactly one cycle, then IDLE.
- The negator has exactly one input mux, selected by state. Only one negation is in flight per cycle.
- start while busy is ignored. Operands are not re-sampled.
- quotient, remainder and div_by_zero hold their values in IDLE until the next accepted start.
- Overflow case −2^(WIDTH−1) / −1 gives quotient 0x80000000 and remainder 0, with no flag.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE, counter=0.
- start accepted in cycle 0 gives:
  - ABS_A in cycle 1, ABS_B in cycle 2.
  - DIV in cycles 3..WIDTH+2, FIX_Q in WIDTH+3, FIX_R in WIDTH+4.
  - done in cycle WIDTH+5 (37 for WIDTH=32).
- Divide-by-zero path: done in cycle 3.
- busy rises in cycle 1 and falls in the cycle after done. A new start is accepted no earlier than the cycle after done.
- reset asserted in any state:
  - The next cycle is IDLE with all outputs at their reset values.
  - No done pulse is produced for the aborted operation.
- The negator is combinational. Its result is registered in the same cycle it is selected.

## Structure
- Shared package div_pkg holds:
  - the state enum (IDLE, ABS_A, ABS_B, DIV, FIX_Q, FIX_R, DONE);
  - DIV_WIDTH = 32;
  - CNT_W = $clog2(DIV_WIDTH)+1.
- One sub-module, twos_negate (parameter WIDTH; ports enable, in, out). It is combinational and passes in through unchanged when enable=0.
- The iteration counter, the A/Q shift register and R live in the top level.

## Test plan
- 100 / 7 → quotient=14, remainder=2, div_by_zero=0, done exactly in cycle 37, busy high in cycles 1..37.
- −100 / 7 → quotient=0xFFFFFFF2, remainder=0xFFFFFFFE.
- 100 / −7 → quotient=0xFFFFFFF2, remainder=2; −100 / −7 → quotient=14, remainder=0xFFFFFFFE.
- 5 / 0 → done in cycle 3, div_by_zero=1, quotient=0, remainder=5. The next start (6/3) clears the flag and yields quotient=2, remainder=0.
- 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. Also 0x80000000 / 1 → quotient=0x80000000, remainder=0.
- start pulsed at cycle 10 of a running divide is ignored, and the original result arrives in cycle 37. Separately, reset at cycle 20 gives busy=0 and all outputs 0 in cycle 21, with no done pulse afterward.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
// Contents:
//   div_state_e : sequencer state encoding
//   DIV_WIDTH   : default operand / result width
//   CNT_W       : width of the iteration counter (holds 0..DIV_WIDTH)
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned CNT_W     = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StAbsA,
        StAbsB,
        StDiv,
        StFixQ,
        StFixR,
        StDone
    } div_state_e;

endpackage

// File: rtl/twos_negate.sv
// Combinational two's-complement negator, shared by all sign steps of the divider.
// Ports:
//   enable_i : 1 = output -in_i, 0 = output in_i unchanged
//   in_i     : operand
//   out_o    : result
module twos_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             enable_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);

    assign out_o = enable_i ? (~in_i + WIDTH'(1)) : in_i;

endmodule

// File: rtl/signed_div_seq.sv
// Multi-cycle signed divider (C truncation semantics) for the DIV instruction.
// Sequence: IDLE -> ABS_A -> ABS_B -> DIV (WIDTH cycles) -> FIX_Q -> FIX_R -> DONE.
// A zero divisor skips straight from ABS_B to DONE with div_by_zero set.
// Ports:
//   clock_i        : rising-edge clock
//   reset_i        : synchronous active-high reset
//   start_i        : request a divide (sampled only in IDLE)
//   dividend_i     : signed dividend, sampled with start_i
//   divisor_i      : signed divisor, sampled with start_i
//   busy_o         : high in every state except IDLE
//   done_o         : one-cycle pulse, results valid
//   quotient_o     : signed quotient (LO)
//   remainder_o    : signed remainder (HI)
//   div_by_zero_o  : set with done_o for a zero divisor, held until next start
module signed_div_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;    // original dividend
    logic [WIDTH-1:0] dvs_q, dvs_d;    // original divisor
    logic [WIDTH-1:0] a_q, a_d;        // |A| shifting out, Q shifting in
    logic [WIDTH-1:0] b_q, b_d;        // |B|
    logic [WIDTH:0]   r_q, r_d;        // partial remainder
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic             neg_en;
    logic [WIDTH-1:0] neg_in;
    logic [WIDTH-1:0] neg_out;
    logic [WIDTH:0]   r_shift;

    twos_negate #(
        .WIDTH (WIDTH)
    ) u_negate (
        .enable_i (neg_en),
        .in_i     (neg_in),
        .out_o    (neg_out)
    );

    // Single input mux for the shared negator, selected by state.
    always_comb begin
        neg_en = 1'b0;
        neg_in = '0;
        case (state_q)
            StAbsA: begin
                neg_in = dvd_q;
                neg_en = dvd_q[WIDTH-1];
            end
            StAbsB: begin
                neg_in = dvs_q;
                neg_en = dvs_q[WIDTH-1];
            end
            StFixQ: begin
                neg_in = a_q;
                neg_en = q_neg_q;
            end
            StFixR: begin
                neg_in = r_q[WIDTH-1:0];
                neg_en = r_neg_q;
            end
            default: begin
                neg_en = 1'b0;
                neg_in = '0;
            end
        endcase
    end

    assign r_shift = {r_q[WIDTH-1:0], a_q[WIDTH-1]};

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    dvd_d   = dividend_i;
                    dvs_d   = divisor_i;
                    q_neg_d = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
                    r_neg_d = dividend_i[WIDTH-1];
                    dbz_d   = 1'b0;
                    state_d = StAbsA;
                end
            end
            StAbsA: begin
                a_d     = neg_out;
                state_d = StAbsB;
            end
            StAbsB: begin
                b_d   = neg_out;
                r_d   = '0;
                cnt_d = '0;
                if (neg_out == '0) begin
                    quo_d   = '0;
                    rem_d   = dvd_q;
                    dbz_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StDiv;
                end
            end
            StDiv: begin
                // Restoring step: subtract only when the result stays non-negative.
                if (r_shift >= {1'b0, b_q}) begin
                    r_d = r_shift - {1'b0, b_q};
                    a_d = {a_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = r_shift;
                    a_d = {a_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFixQ;
                end
            end
            StFixQ: begin
                quo_d   = neg_out;
                state_d = StFixR;
            end
            StFixR: begin
                rem_d   = neg_out;
                state_d = StDone;
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            dvd_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);
    assign quotient_o    = quo_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_signed_div_seq.sv
// Scoreboard bench for signed_div_seq: stimulus pushes expected results (from plain
// signed arithmetic) into a queue; a monitor pops and compares on every done pulse,
// and checks busy against the expected activity window each cycle.
module tb_signed_div_seq;

    logic        clk;
    logic        reset_i;
    logic        start_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic        div_by_zero_o;

    signed_div_seq #(
        .WIDTH (32)
    ) dut (
        .clock_i       (clk),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   busy_lo = 0;
    int   busy_hi = 0;
    bit   mon_en  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: busy window every cycle, results on each done pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", {31'd0, busy_o}, {31'd0, (cyc > busy_lo) && (cyc <= busy_hi)});
            if (done_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("quotient", quotient_o, e.q);
                    chk("remainder", remainder_o, e.r);
                    chk("div_by_zero", {31'd0, div_by_zero_o}, {31'd0, e.dbz});
                end
            end
        end
    end

    // Reference: C truncating division on signed 64-bit values.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint qq;
        longint rr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            e.q   = 32'd0;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            qq    = sa / sb;
            rr    = sa % sb;
            e.q   = qq[31:0];
            e.r   = rr[31:0];
            e.dbz = 1'b0;
        end
        e.cyc = 0;
        return e;
    endfunction

    // Called at negedge+1 with the DUT idle; returns one cycle later.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e     = model(a, b);
        e.cyc = cyc + (e.dbz ? 3 : 37);
        exp_q.push_back(e);
        busy_lo    = cyc;
        busy_hi    = e.cyc;
        start_i    = 1'b1;
        dividend_i = a;
        divisor_i  = b;
        @(negedge clk); #1;
        start_i    = 1'b0;
        dividend_i = $urandom;
        divisor_i  = $urandom;
    endtask

    // Wait until the scoreboard drains, then step into the cycle after done.
    task automatic wait_idle();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 32'd1, 32'd0);
            exp_q.delete();
        end
        @(negedge clk); #1;
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b);
        issue(a, b);
        wait_idle();
    endtask

    initial begin
        reset_i    = 1'b1;
        start_i    = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_quotient", quotient_o, 32'd0);
        chk("rst_remainder", remainder_o, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero_o}, 32'd0);
        reset_i = 1'b0;
        mon_en  = 1'b1;
        @(negedge clk); #1;

        // Directed cases
        run(32'd100, 32'd7);
        run(-32'sd100, 32'd7);
        run(32'd100, -32'sd7);
        run(-32'sd100, -32'sd7);
        run(32'd5, 32'd0);
        run(32'd6, 32'd3);
        run(32'h8000_0000, 32'hFFFF_FFFF);
        run(32'h8000_0000, 32'd1);

        // start while busy is ignored
        begin
            int c0;
            c0 = cyc;
            issue(32'd100, 32'd7);
            while (cyc < c0 + 10) begin
                @(negedge clk); #1;
            end
            start_i    = 1'b1;
            dividend_i = 32'd1;
            divisor_i  = 32'd1;
            @(negedge clk); #1;
            start_i = 1'b0;
            wait_idle();
        end

        // reset mid-divide aborts without a done pulse
        begin
            int c0;
            c0 = cyc;
            issue(32'd12345, -32'sd3);
            while (cyc < c0 + 20) begin
                @(negedge clk); #1;
            end
            reset_i = 1'b1;
            exp_q.delete();
            busy_lo = 0;
            busy_hi = 0;
            @(negedge clk); #1;
            chk("abort_cycle", cyc, c0 + 21);
            chk("abort_busy", {31'd0, busy_o}, 32'd0);
            chk("abort_done", {31'd0, done_o}, 32'd0);
            chk("abort_quotient", quotient_o, 32'd0);
            chk("abort_remainder", remainder_o, 32'd0);
            chk("abort_dbz", {31'd0, div_by_zero_o}, 32'd0);
            reset_i = 1'b0;
            repeat (45) @(negedge clk);
            #1;
        end

        // Randomized mix
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: ;
                1: begin
                    a = 32'($urandom_range(0, 2000)) - 32'd1000;
                    b = 32'($urandom_range(0, 60)) - 32'd30;
                end
                2: b = 32'd0;
                3: begin
                    a = 32'h8000_0000;
                    if ($urandom_range(0, 1) == 0) b = 32'hFFFF_FFFF;
                end
                4: b = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFF_FFFF);
                default: a = 32'($urandom_range(0, 200)) - 32'd100;
            endcase
            run(a, b);
        end

        if (exp_q.size() != 0) chk("leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
